// File: rtl/simon_pkt_tx.sv
// Serialises SIMON cipher result blocks into byte packets: info, length, then data MSB-first.
// A one-entry pending buffer absorbs a block that arrives while a packet is still streaming.
module simon_pkt_tx #(
  parameter int N = 16
) (
  input  logic               clk,
  input  logic               nR,
  input  logic               donePkt,
  input  logic [1:0][N-1:0]  inData,
  input  logic [7:0]         info,
  input  logic               outReady,
  output logic               outValid,
  output logic [7:0]         outByte,
  output logic               lastByte,
  output logic               busy,
  output logic               overflow
);

  localparam int BYTES = N / 4;
  localparam int IW    = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE, HDR, LEN, DATA} state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   idx_reg, idx_next;

  logic [2*N-1:0]  act_data_reg;
  logic [7:0]      act_info_reg;
  logic [2*N-1:0]  pend_data_reg;
  logic [7:0]      pend_info_reg;
  logic            pend_valid_reg;
  logic            overflow_reg;

  logic            xfer;
  logic            at_last;
  logic            last_xfer;
  logic [7:0]      data_bytes [BYTES];

  // Byte 0 is the most significant byte of inData[1].
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_bytes
      assign data_bytes[gi] = act_data_reg[2*N-1-8*gi -: 8];
    end
  endgenerate

  assign xfer      = (state_reg != IDLE) && outReady;
  assign at_last   = (state_reg == DATA) && (idx_reg == IW'(BYTES - 1));
  assign last_xfer = at_last && outReady;

  always_ff @(posedge clk or posedge nR) begin
    if (nR) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (donePkt) state_next = HDR;
      end
      HDR: begin
        if (xfer) state_next = LEN;
      end
      LEN: begin
        if (xfer) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (xfer) begin
          if (at_last) begin
            state_next = (pend_valid_reg || donePkt) ? HDR : IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    outValid = (state_reg != IDLE);
    lastByte = at_last;
    outByte  = 8'h00;
    case (state_reg)
      HDR:     outByte = act_info_reg;
      LEN:     outByte = 8'(BYTES);
      DATA:    outByte = data_bytes[idx_reg];
      default: outByte = 8'h00;
    endcase
  end

  // Active packet only changes when idle or on its own last-byte transfer,
  // which keeps the presented byte stable under backpressure.
  always_ff @(posedge clk or posedge nR) begin
    if (nR) begin
      act_data_reg   <= '0;
      act_info_reg   <= '0;
      pend_data_reg  <= '0;
      pend_info_reg  <= '0;
      pend_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (donePkt) begin
        act_data_reg <= inData;
        act_info_reg <= info;
      end
    end else if (last_xfer) begin
      if (pend_valid_reg) begin
        act_data_reg <= pend_data_reg;
        act_info_reg <= pend_info_reg;
        if (donePkt) begin
          pend_data_reg <= inData;
          pend_info_reg <= info;
        end else begin
          pend_valid_reg <= 1'b0;
        end
      end else if (donePkt) begin
        act_data_reg <= inData;
        act_info_reg <= info;
      end
    end else if (donePkt) begin
      if (!pend_valid_reg) begin
        pend_data_reg  <= inData;
        pend_info_reg  <= info;
        pend_valid_reg <= 1'b1;
      end else begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign busy     = pend_valid_reg;
  assign overflow = overflow_reg;

endmodule

// File: doc/simon_pkt_tx.md
SIMON_PKT_TX -- requirements
Module: simon_pkt_tx

Interface
REQ-001 SHALL have parameter N, default 16, meaning SIMON word width in bits; legal values 16, 24, 32, 48, 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port nR, input, 1; reset is asynchronous and active-high (nR=1 resets immediately, independent of clk).
REQ-004 SHALL have port donePkt, input, 1, single-cycle pulse marking inData/info valid.
REQ-005 SHALL have port inData, input, [1:0][N-1:0], cipher result block.
REQ-006 SHALL have port info, input, 8, header byte echoed into the outgoing packet.
REQ-007 SHALL have port outReady, input, 1, downstream byte accept.
REQ-008 SHALL have port outValid, output, 1, outByte valid.
REQ-009 SHALL have port outByte, output, 8, current stream byte.
REQ-010 SHALL have port lastByte, output, 1, high with the final byte of a packet.
REQ-011 SHALL have port busy, output, 1, high when the pending buffer is occupied.
REQ-012 SHALL have port overflow, output, 1, sticky: a packet was dropped.

Function
REQ-013 SHALL emit packets of 2+N/4 bytes: info; length byte = N/4; then inData MSB-first (inData[1][N-1:N-8] ... inData[0][7:0]).
REQ-014 SHALL use FSM states IDLE, HDR, LEN, DATA; IDLE->HDR on packet load; HDR->LEN and LEN->DATA on transfer; DATA->IDLE on last-byte transfer with no packet queued, else DATA->HDR.
REQ-015 SHALL count a byte transferred only in a cycle with outValid=1 and outReady=1.
REQ-016 SHALL hold outByte, lastByte and outValid stable while outValid=1 and outReady=0.
REQ-017 SHALL assert outValid, with the info byte, in the cycle after donePkt when IDLE (latency 1).
REQ-018 SHALL keep outValid low in IDLE; outByte is 8'h00 whenever outValid=0.
REQ-019 SHALL use a DATA byte index counter of ceil(log2(N/4)) bits, reset to 0 on entry to DATA; lastByte=1 when index = N/4-1.
REQ-020 SHALL capture donePkt arriving while not IDLE into a one-entry pending buffer (inData and info) and set busy.
REQ-021 SHALL load the pending packet on the last-byte transfer so HDR follows immediately, with no idle cycle between packets.
REQ-022 SHALL, when donePkt coincides with the last-byte transfer and pending is empty, load the new packet directly as the next active packet (no bubble, busy stays 0).
REQ-023 SHALL, when donePkt coincides with the last-byte transfer and pending is full, promote pending to active and capture the new packet into pending.
REQ-024 SHALL, on donePkt with pending full and no last-byte transfer that cycle, drop the new packet, set overflow, and leave the active and pending packets untouched.
REQ-025 SHALL clear overflow only by reset.

Reset
REQ-026 SHALL, while nR=1, force state IDLE, outValid=0, outByte=8'h00, lastByte=0, busy=0, overflow=0, byte index 0, pending cleared.
REQ-027 SHALL abort any packet in flight on reset; no partial packet resumes afterwards.
REQ-028 SHALL ignore donePkt in any cycle where nR=1.

Verification
REQ-029 SHALL cover single packet: N=16, info=8'hA5, inData={16'h1234,16'h5678}, outReady=1 -> bytes A5,04,12,34,56,78 in cycles k+1..k+6; lastByte only with 78; outValid=0 at k+7.
REQ-030 SHALL cover backpressure: outReady=0 for 3 cycles while outByte=8'h34 -> 8'h34 held, outValid held at 1, sequence completes unchanged.
REQ-031 SHALL cover back-to-back: second donePkt (info=8'h3C) during packet 1 -> busy=1; 8'h3C follows 8'h78 in the next cycle; busy=0 after 8'h3C transfers.
REQ-032 SHALL cover overflow: third donePkt while busy=1 and not on a last-byte transfer -> overflow=1 sticky; packets 1 and 2 are emitted intact.
REQ-033 SHALL cover coincidence: donePkt in the same cycle as the 8'h78 transfer, pending empty -> new info byte in the next cycle, busy stays 0.
REQ-034 SHALL cover mid-packet reset: nR pulsed after byte 8'h04 -> outputs 0 immediately; after release, outValid stays 0 until the next donePkt.
